// File: rtl/wb_cmd_pkg.sv
// Shared types and sizing for the Wishbone command initiator.
// Holds the FSM state enum, the default bus timeout and the counter widths.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int TIMEOUT_DEF = 255;
  localparam int TXN_CNT_W   = 16;
  localparam int TMO_CNT_W   = 8;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: one command in, one bus cycle, one response out.
// Ports: cmd_* valid/ready command port, rsp_* valid/ready response port,
//        wbm_* Wishbone master side, txn_cnt_o acked count, tmo_cnt_o timeout count.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDR_W-1:0]    cmd_adr_i,
  input  logic [DATA_W-1:0]    cmd_dat_i,
  input  logic [DATA_W/8-1:0]  cmd_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATA_W-1:0]    rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [DATA_W/8-1:0]  wbm_sel_o,
  output logic [ADDR_W-1:0]    wbm_adr_o,
  output logic [DATA_W-1:0]    wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic [DATA_W-1:0]    wbm_dat_i,
  output logic [TXN_CNT_W-1:0] txn_cnt_o,
  output logic [TMO_CNT_W-1:0] tmo_cnt_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_e state_q, state_d;

  logic                 we_q,   we_d;
  logic [ADDR_W-1:0]    adr_q,  adr_d;
  logic [DATA_W-1:0]    dat_q,  dat_d;
  logic [SEL_W-1:0]     sel_q,  sel_d;
  logic [CNT_W-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0]    rdat_q, rdat_d;
  logic                 err_q,  err_d;
  logic [TXN_CNT_W-1:0] txn_q,  txn_d;
  logic [TMO_CNT_W-1:0] tmo_q,  tmo_d;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      wait_q  <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      txn_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      wait_q  <= wait_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    wait_d  = wait_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    txn_d   = txn_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          sel_d   = cmd_sel_i;
          wait_d  = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // Leaves at WAIT_LAST at the latest, so the +1 never wraps.
        wait_d = wait_q + CNT_W'(1);
        // Ack is tested first so it wins over a same-edge timeout.
        if (wbm_ack_i) begin
          rdat_d  = we_q ? '0 : wbm_dat_i;
          err_d   = 1'b0;
          txn_d   = txn_q + TXN_CNT_W'(1);
          state_d = ST_RESP;
        end else if (wait_q == WAIT_LAST) begin
          rdat_d  = '0;
          err_d   = 1'b1;
          if (tmo_q != '1) tmo_d = tmo_q + TMO_CNT_W'(1);
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and bus strobes are pure state decodes, so the async
  // reset drops cyc/stb immediately.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign wbm_cyc_o   = (state_q == ST_BUS);
  assign wbm_stb_o   = (state_q == ST_BUS);
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_dat_o   = rdat_q;
  assign rsp_err_o   = err_q;
  assign txn_cnt_o   = txn_q;
  assign tmo_cnt_o   = tmo_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master with a transaction-level reference model.
// Directed plan cases, randomized commands, timeout saturation and reset mid-bus.
module tb_wb_cmd_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, wwe, ack;
  logic [3:0]  wsel;
  logic [31:0] wadr, wdat_o, wdat_i;
  logic [15:0] txn_cnt;
  logic [7:0]  tmo_cnt;

  int vecs = 0;
  int errs = 0;
  int exp_txn = 0;
  int exp_tmo = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
    .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(wwe),
    .wbm_sel_o(wsel), .wbm_adr_o(wadr), .wbm_dat_o(wdat_o),
    .wbm_ack_i(ack), .wbm_dat_i(wdat_i),
    .txn_cnt_o(txn_cnt), .tmo_cnt_o(tmo_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One command end to end; slave acks after `waits` wait states
  // (waits >= TMO means the slave never acks in time).
  task automatic txn(input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input int waits, input logic [31:0] rdata,
                     input int hold);
    int stbc;
    int exp_stb;
    logic exp_ack;
    logic [31:0] exp_dat;
    exp_ack = (waits + 1 <= TMO);
    exp_stb = exp_ack ? waits + 1 : TMO;
    exp_dat = (exp_ack && !we) ? rdata : 32'h0;
    if (exp_ack) exp_txn = (exp_txn + 1) % 65536;
    else if (exp_tmo < 255) exp_tmo++;

    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_we = $urandom; cmd_adr = $urandom;
    cmd_dat = $urandom; cmd_sel = 4'($urandom);

    stbc = 0;
    while (stb && stbc < TMO + 4) begin
      stbc++;
      chk("bus_cyc", cyc, 1);
      chk("bus_we", wwe, we);
      chk("bus_adr", wadr, adr);
      chk("bus_dat", wdat_o, dat);
      chk("bus_sel", wsel, sel);
      ack = (stbc == waits + 1);
      wdat_i = ack ? rdata : $urandom;
      @(posedge clk); #1;
      ack = 1'b0;
    end
    chk("stb_cycles", stbc, exp_stb);
    chk("cyc_after", cyc, 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_err", rsp_err, !exp_ack);
    chk("txn_cnt", txn_cnt, exp_txn);
    chk("tmo_cnt", tmo_cnt, exp_tmo);
    chk("cmd_ready_resp", cmd_ready, 0);

    // Backpressure with junk command and stray acks that must be ignored.
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = $urandom;
      ack = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_dat", rsp_dat, exp_dat);
      chk("hold_err", rsp_err, !exp_ack);
      chk("hold_ready", cmd_ready, 0);
      chk("hold_stb", stb, 0);
      chk("hold_txn", txn_cnt, exp_txn);
      chk("hold_tmo", tmo_cnt, exp_tmo);
    end
    cmd_valid = 1'b0;
    ack = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("idle_ready", cmd_ready, 1);

    // Stray ack in IDLE.
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("idle_ack_stb", stb, 0);
    chk("idle_ack_txn", txn_cnt, exp_txn);
    chk("idle_ack_tmo", tmo_cnt, exp_tmo);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; ack = 1'b0; wdat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_rerr", rsp_err, 0);
    chk("rst_rdat", rsp_dat, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_we", wwe, 0);
    chk("rst_adr", wadr, 0);
    chk("rst_wdat", wdat_o, 0);
    chk("rst_sel", wsel, 0);
    chk("rst_txn", txn_cnt, 0);
    chk("rst_tmo", tmo_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    txn(1'b1, 32'h3000_0000, 32'hA5A5_5A5A, 4'hF, 0, 32'hDEAD_BEEF, 0);
    txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 3, 32'h1234_5678, 0);
    txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, 100, 32'h0, 0);
    txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, TMO - 1, 32'hCAFE_F00D, 0);
    txn(1'b1, 32'h3000_0010, 32'h1111_2222, 4'h5, 1, 32'h0, 5);
    txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, 0, 32'h9999_0001, 1);

    for (int k = 0; k < 200; k++)
      txn(1'(($urandom)), $urandom, $urandom, 4'($urandom),
          int'($urandom_range(0, TMO + 2)), $urandom,
          int'($urandom_range(0, 3)));

    for (int k = 0; k < 260; k++)
      txn(1'b0, $urandom, $urandom, 4'hF, TMO + 5, $urandom, 0);
    chk("tmo_saturated", tmo_cnt, 8'hFF);

    // Reset while stb is high.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_stb_pre", stb, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_cyc", cyc, 0);
    chk("mid_stb", stb, 0);
    chk("mid_rvalid", rsp_valid, 0);
    chk("mid_txn", txn_cnt, 0);
    chk("mid_tmo", tmo_cnt, 0);
    exp_txn = 0;
    exp_tmo = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_ready", cmd_ready, 1);
    chk("post_rvalid", rsp_valid, 0);
    txn(1'b1, 32'h3000_0024, 32'h0BAD_F00D, 4'hC, 2, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
